// File: rtl/expr_pkg.sv
// Shared types and ASCII constants for the streaming expression recogniser.
package expr_pkg;

    typedef enum logic [1:0] {
        S_START,
        S_NUM,
        S_CLOSE,
        S_ERR
    } state_e;

    localparam int unsigned CLS_W = 3;

    typedef enum logic [CLS_W-1:0] {
        C_DIGIT,
        C_OP,
        C_LP,
        C_RP,
        C_OTHER
    } char_class_e;

    localparam logic [7:0] CH_0     = 8'd48;
    localparam logic [7:0] CH_9     = 8'd57;
    localparam logic [7:0] CH_PLUS  = 8'd43;
    localparam logic [7:0] CH_MINUS = 8'd45;
    localparam logic [7:0] CH_STAR  = 8'd42;
    localparam logic [7:0] CH_SLASH = 8'd47;
    localparam logic [7:0] CH_LP    = 8'd40;
    localparam logic [7:0] CH_RP    = 8'd41;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier; '-' and '/' count as operators only when EXT_OPS is set.
module expr_char_class
    import expr_pkg::*;
#(
    parameter int unsigned EXT_OPS = 1
) (
    input  logic [7:0]       i_ch,
    output logic [CLS_W-1:0] o_class
);

    char_class_e w_cls;

    always_comb begin
        w_cls = C_OTHER;
        if (i_ch >= CH_0 && i_ch <= CH_9) begin
            w_cls = C_DIGIT;
        end else begin
            case (i_ch)
                CH_PLUS, CH_STAR:   w_cls = C_OP;
                CH_MINUS, CH_SLASH: w_cls = (EXT_OPS != 0) ? C_OP : C_OTHER;
                CH_LP:              w_cls = C_LP;
                CH_RP:              w_cls = C_RP;
                default:            w_cls = C_OTHER;
            endcase
        end
    end

    assign o_class = w_cls;

endmodule

// File: rtl/expr_string_checker.sv
// Streaming arithmetic-expression recogniser: flags complete expressions and latches syntax errors until clr.
module expr_string_checker
    import expr_pkg::*;
#(
    parameter  int unsigned MAX_DIGITS = 4,
    parameter  int unsigned MAX_DEPTH  = 7,
    parameter  int unsigned EXT_OPS    = 1,
    localparam int unsigned DW         = (MAX_DEPTH > 0) ? $clog2(MAX_DEPTH + 1) : 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [7:0]    in,
    output logic          out,
    output logic          err,
    output logic [DW-1:0] depth
);

    localparam int unsigned  CW        = $clog2(MAX_DIGITS + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(MAX_DEPTH);
    localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_DIGITS);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [DW-1:0]     r_depth;
    logic [DW-1:0]     w_depth_nxt;
    logic [CW-1:0]     r_digit_cnt;
    logic [CW-1:0]     w_digit_cnt_nxt;
    logic              r_out;
    logic              r_err;
    logic              w_out_nxt;
    logic              w_err_nxt;
    logic [CLS_W-1:0]  w_cls_raw;
    char_class_e       w_cls;

    expr_char_class #(
        .EXT_OPS (EXT_OPS)
    ) u_class (
        .i_ch    (in),
        .o_class (w_cls_raw)
    );

    assign w_cls = char_class_e'(w_cls_raw);

    // State, counters and decoded flags advance only on accepted characters.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= S_START;
            r_depth     <= '0;
            r_digit_cnt <= '0;
            r_out       <= 1'b0;
            r_err       <= 1'b0;
        end else if (in_valid) begin
            r_state     <= w_state_nxt;
            r_depth     <= w_depth_nxt;
            r_digit_cnt <= w_digit_cnt_nxt;
            r_out       <= w_out_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_depth_nxt     = r_depth;
        w_digit_cnt_nxt = r_digit_cnt;

        case (r_state)
            S_START: begin
                if (w_cls == C_DIGIT) begin
                    w_state_nxt     = S_NUM;
                    w_digit_cnt_nxt = CW'(1);
                end else if (w_cls == C_LP && r_depth < DEPTH_MAX) begin
                    w_depth_nxt = DW'(r_depth + DW'(1));
                end else begin
                    w_state_nxt = S_ERR;
                end
            end
            S_NUM: begin
                if (w_cls == C_DIGIT && r_digit_cnt < CNT_MAX) begin
                    w_digit_cnt_nxt = CW'(r_digit_cnt + CW'(1));
                end else if (w_cls == C_OP) begin
                    w_state_nxt     = S_START;
                    w_digit_cnt_nxt = '0;
                end else if (w_cls == C_RP && r_depth != '0) begin
                    w_state_nxt = S_CLOSE;
                    w_depth_nxt = DW'(r_depth - DW'(1));
                end else begin
                    w_state_nxt = S_ERR;
                end
            end
            S_CLOSE: begin
                if (w_cls == C_OP) begin
                    w_state_nxt = S_START;
                end else if (w_cls == C_RP && r_depth != '0) begin
                    w_depth_nxt = DW'(r_depth - DW'(1));
                end else begin
                    w_state_nxt = S_ERR;
                end
            end
            default: begin
                w_state_nxt = S_ERR;
            end
        endcase

        // Flags are decoded from the next state so they line up with the registered depth.
        w_out_nxt = (w_state_nxt == S_NUM || w_state_nxt == S_CLOSE) && (w_depth_nxt == '0);
        w_err_nxt = (w_state_nxt == S_ERR);
    end

    assign out   = r_out;
    assign err   = r_err;
    assign depth = r_depth;

endmodule

// File: tb/tb_expr_string_checker.sv
// Self-checking bench: four parameterisations share one character stream, checked against a grammar model.
module tb_expr_string_checker;

    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       in_valid;
    logic [7:0] ch;

    logic       o_out [NI];
    logic       o_err [NI];
    logic [2:0] o_dep [NI];
    logic [2:0] dep0;
    logic [2:0] dep1;
    logic [1:0] dep2;
    logic [0:0] dep3;

    int cfg_md  [NI] = '{4, 4, 4, 4};
    int cfg_mdp [NI] = '{7, 7, 2, 0};
    int cfg_ext [NI] = '{1, 0, 1, 1};

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] hist [$];

    always #5 clk = ~clk;

    expr_string_checker #(.MAX_DIGITS(4), .MAX_DEPTH(7), .EXT_OPS(1)) u_def (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in(ch),
        .out(o_out[0]), .err(o_err[0]), .depth(dep0));
    expr_string_checker #(.MAX_DIGITS(4), .MAX_DEPTH(7), .EXT_OPS(0)) u_ext0 (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in(ch),
        .out(o_out[1]), .err(o_err[1]), .depth(dep1));
    expr_string_checker #(.MAX_DIGITS(4), .MAX_DEPTH(2), .EXT_OPS(1)) u_d2 (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in(ch),
        .out(o_out[2]), .err(o_err[2]), .depth(dep2));
    expr_string_checker #(.MAX_DIGITS(4), .MAX_DEPTH(0), .EXT_OPS(1)) u_d0 (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in(ch),
        .out(o_out[3]), .err(o_err[3]), .depth(dep3));

    assign o_dep[0] = dep0;
    assign o_dep[1] = dep1;
    assign o_dep[2] = {1'b0, dep2};
    assign o_dep[3] = {2'b00, dep3};

    // Grammar reference: operand positions take a digit or '(', a digit may be followed by
    // a digit (run-length bounded), an operator or ')', a ')' by an operator or ')'.
    // Paren balance must stay within [0, mdp]. The first violation is sticky.
    function automatic void model(input int md, input int mdp, input int ext,
                                  output bit o, output bit e, output int d);
        int  run  = 0;
        int  bal  = 0;
        int  prev = 0;
        o = 1'b0;
        e = 1'b0;
        d = 0;
        foreach (hist[i]) begin
            logic [7:0] c;
            bit dig, op, lp, rp, legal;
            c     = hist[i];
            dig   = (c >= 8'd48 && c <= 8'd57);
            op    = (c == 8'd43) || (c == 8'd42) || (ext != 0 && (c == 8'd45 || c == 8'd47));
            lp    = (c == 8'd40);
            rp    = (c == 8'd41);
            legal = 1'b0;
            if (prev == 0)      legal = dig || (lp && bal < mdp);
            else if (prev == 1) legal = (dig && run < md) || op || (rp && bal > 0);
            else                legal = op || (rp && bal > 0);
            if (!legal) begin
                e = 1'b1;
                d = bal;
                return;
            end
            run  = dig ? ((prev == 1) ? run + 1 : 1) : 0;
            prev = dig ? 1 : (rp ? 2 : 0);
            if (lp) bal = bal + 1;
            if (rp) bal = bal - 1;
        end
        d = bal;
        o = (prev != 0) && (bal == 0);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit eo, ee;
        int ed;
        for (int k = 0; k < NI; k++) begin
            model(cfg_md[k], cfg_mdp[k], cfg_ext[k], eo, ee, ed);
            chk($sformatf("out[%0d]", k),   int'(o_out[k]), int'(eo));
            chk($sformatf("err[%0d]", k),   int'(o_err[k]), int'(ee));
            chk($sformatf("depth[%0d]", k), int'(o_dep[k]), ed);
            chk($sformatf("excl[%0d]", k),  int'(o_out[k] & o_err[k]), 0);
        end
    endtask

    task automatic step(input logic [7:0] c);
        ch       = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        hist.push_back(c);
        check_all();
    endtask

    task automatic idle();
        ch       = 8'($urandom);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all();
    endtask

    // clr wins over a simultaneous valid '4', which must not be consumed.
    task automatic do_clr();
        clr      = 1'b1;
        in_valid = 1'b1;
        ch       = 8'd52;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        hist.delete();
        check_all();
    endtask

    task automatic run(input string s, input string exp_out);
        for (int i = 0; i < s.len(); i++) begin
            step(s[i]);
            if (i < exp_out.len())
                chk($sformatf("lit_out '%s'@%0d", s, i), int'(o_out[0]), int'(exp_out[i] == 8'd49));
        end
    endtask

    initial begin
        clr      = 1'b1;
        in_valid = 1'b0;
        ch       = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        check_all();

        run("12+3", "1101");
        run("*", "0");
        chk("lit_err_after_star", int'(o_err[0]), 0);

        do_clr();
        run("((7))", "00001");
        chk("lit_depth_closed", int'(o_dep[0]), 0);
        run(")", "0");
        chk("lit_err_extra_rp", int'(o_err[0]), 1);
        run("5+5", "000");
        chk("lit_err_sticky", int'(o_err[0]), 1);
        do_clr();
        chk("lit_clr_err", int'(o_err[0]), 0);

        run("1234", "1111");
        run("5", "0");
        chk("lit_err_5th_digit", int'(o_err[0]), 1);
        do_clr();
        run("1234+56", "1111011");

        do_clr();
        run("9-1", "101");
        chk("lit_ext0_err", int'(o_err[1]), 1);
        chk("lit_ext1_err", int'(o_err[0]), 0);

        do_clr();
        run("(", "0");
        chk("lit_d0_err", int'(o_err[3]), 1);
        run("((", "00");
        chk("lit_d2_depth", int'(o_dep[2]), 2);
        chk("lit_d2_err", int'(o_err[2]), 1);
        chk("lit_def_depth3", int'(o_dep[0]), 3);

        do_clr();
        run("3", "1");
        idle();
        idle();
        chk("lit_hold_out", int'(o_out[0]), 1);
        run("+", "0");
        do_clr();
        chk("lit_clr_depth", int'(o_dep[0]), 0);
        run("+", "0");
        chk("lit_4_not_consumed", int'(o_err[0]), 1);

        do_clr();
        begin
            string pool;
            pool = "0123456789012+*-/((()))x ";
            for (int n = 0; n < 500; n++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r < 3)       do_clr();
                else if (r < 13) idle();
                else             step(pool[$urandom_range(0, pool.len() - 1)]);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
